tr_step_ctrl: RTL and testbench

Second-generation tracking-mode stepper controller. Each `data_valid` strobe samples the ADC reading `x` against the table target `x0`. The block closes the loop by driving step/direction/enable to the stepper driver, using three speed zones, a deadzone hold with hysteresis, a safe direction-reversal sequence, a signed step position counter and a stale-data watchdog. It sits between the ADC reader and the stepper driver pins, in the same clock domain as the ADC strobe.

---
 rtl/tr_step_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tr_step_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tr_step_ctrl.sv
// tr_step_ctrl: tracking-mode stepper loop controller.
// Zoned step rate, deadzone hold, safe reversal, watchdog.
module tr_step_ctrl #(
  parameter int WIDTH_IN  = 12,
  parameter int DX1       = 10,
  parameter int DX2       = 100,
  parameter int DEADZONE  = 9,
  parameter int P_FAR     = 1000,
  parameter int P_MID     = 10000,
  parameter int P_NEAR    = 100000,
  parameter int PULSE_W   = 250,
  parameter int DIR_SETUP = 500,
  parameter int TIMEOUT   = 5000000,
  parameter int CNT_W     = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tr_mode_enable,
  input  logic                data_valid,
  input  logic [WIDTH_IN-1:0] x,
  input  logic [WIDTH_IN-1:0] x0,
  output logic                drv_step,
  output logic                drv_dir,
  output logic                drv_enable_SM,
  output logic [CNT_W-1:0]    step_count,
  output logic                stale
);

  localparam int PM1 = (P_FAR > P_MID) ? P_FAR : P_MID;
  localparam int PMAX = (PM1 > P_NEAR) ? PM1 : P_NEAR;
  localparam int PER_W = $clog2(PMAX + 1);
  localparam int PW_W = $clog2(PULSE_W + 1);
  localparam int DS_W = $clog2(DIR_SETUP + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_HOLD, S_TRACK, S_REVERSE
  } state_t;

  typedef enum logic [1:0] {
    Z_NONE, Z_NEAR, Z_MID, Z_FAR
  } zone_t;

  state_t state, state_d;
  zone_t zone;

  logic [WIDTH_IN-1:0] dx_abs, dx_new;
  logic                want_dir;
  logic                have_sample;
  logic [WD_W-1:0]     wd_cnt;
  logic [PER_W-1:0]    per_cnt, zone_per;
  logic [PW_W-1:0]     pw_cnt;
  logic [DS_W-1:0]     setup_cnt;
  logic                timeout_hit;
  logic                abort;
  logic                step_start;
  logic                dir_load;

  assign dx_new = (x >= x0) ? (x - x0) : (x0 - x);
  assign timeout_hit = !data_valid &&
    (wd_cnt == WD_W'(TIMEOUT - 1));
  assign abort = (state != S_IDLE) &&
    (!tr_mode_enable || timeout_hit);
  assign drv_enable_SM = (state == S_TRACK) ||
    (state == S_REVERSE);

  always_comb begin
    zone = Z_NONE;
    if (dx_abs >= WIDTH_IN'(DX2))
      zone = Z_FAR;
    else if (dx_abs >= WIDTH_IN'(DX1))
      zone = Z_MID;
    else if (dx_abs != '0)
      zone = Z_NEAR;
  end

  always_comb begin
    zone_per = '0;
    case (zone)
      Z_FAR:   zone_per = PER_W'(P_FAR - 1);
      Z_MID:   zone_per = PER_W'(P_MID - 1);
      Z_NEAR:  zone_per = PER_W'(P_NEAR - 1);
      default: zone_per = '0;
    endcase
  end

  // Exits from TRACK wait for the pulse to finish.
  always_comb begin
    state_d = state;
    step_start = 1'b0;
    dir_load = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tr_mode_enable && have_sample && !stale)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        if (dx_abs >= WIDTH_IN'(DEADZONE)) begin
          if (want_dir == drv_dir) begin
            state_d = S_TRACK;
          end else begin
            state_d = S_REVERSE;
            dir_load = 1'b1;
          end
        end
      end
      S_TRACK: begin
        if (!drv_step && zone == Z_NONE) begin
          state_d = S_HOLD;
        end else if (!drv_step && want_dir != drv_dir) begin
          state_d = S_REVERSE;
          dir_load = 1'b1;
        end else if (per_cnt == '0 && zone != Z_NONE) begin
          step_start = 1'b1;
        end
      end
      S_REVERSE: begin
        if (want_dir != drv_dir)
          dir_load = 1'b1;
        else if (setup_cnt == '0)
          state_d = (dx_abs != '0) ? S_TRACK : S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      step_start = 1'b0;
      dir_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dx_abs <= '0;
      want_dir <= 1'b0;
      have_sample <= 1'b0;
      wd_cnt <= '0;
      stale <= 1'b0;
      drv_dir <= 1'b0;
      drv_step <= 1'b0;
      setup_cnt <= '0;
      per_cnt <= '0;
      pw_cnt <= '0;
      step_count <= '0;
    end else begin
      state <= state_d;
      if (data_valid) begin
        dx_abs <= dx_new;
        if (x < x0)
          want_dir <= 1'b1;
        else if (x > x0)
          want_dir <= 1'b0;
        have_sample <= 1'b1;
        wd_cnt <= '0;
        stale <= 1'b0;
      end else begin
        if (wd_cnt != WD_W'(TIMEOUT))
          wd_cnt <= wd_cnt + WD_W'(1);
        if (timeout_hit)
          stale <= 1'b1;
      end
      if (dir_load) begin
        drv_dir <= want_dir;
        setup_cnt <= DS_W'(DIR_SETUP - 1);
      end else if (setup_cnt != '0) begin
        setup_cnt <= setup_cnt - DS_W'(1);
      end
      if (state != S_TRACK)
        per_cnt <= '0;
      else if (step_start)
        per_cnt <= zone_per;
      else if (per_cnt != '0)
        per_cnt <= per_cnt - PER_W'(1);
      if (abort) begin
        drv_step <= 1'b0;
      end else if (step_start) begin
        drv_step <= 1'b1;
        pw_cnt <= PW_W'(PULSE_W - 1);
      end else if (drv_step) begin
        if (pw_cnt == '0)
          drv_step <= 1'b0;
        else
          pw_cnt <= pw_cnt - PW_W'(1);
      end
      if (step_start)
        step_count <= drv_dir ? step_count + CNT_W'(1)
                              : step_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tr_step_ctrl.sv
// tb_tr_step_ctrl: vector table plus corner sequences
// for the tracking stepper controller.
module tb_tr_step_ctrl;

  localparam int WIDTH_IN  = 12;
  localparam int P_FAR     = 20;
  localparam int P_MID     = 40;
  localparam int P_NEAR    = 80;
  localparam int PULSE_W   = 5;
  localparam int DIR_SETUP = 7;
  localparam int TIMEOUT   = 3000;
  localparam int CNT_W     = 24;
  localparam int NVEC      = 9;

  typedef struct {
    logic [WIDTH_IN-1:0] x;
    logic [WIDTH_IN-1:0] x0;
    int                  period;
    bit                  dir;
  } vec_t;

  typedef struct {
    int cyc;
    bit dir;
    int count;
    int model;
  } rise_t;

  typedef struct {
    int period;
    bit dir;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                tr_mode_enable;
  logic                data_valid;
  logic [WIDTH_IN-1:0] x;
  logic [WIDTH_IN-1:0] x0;
  logic                drv_step;
  logic                drv_dir;
  logic                drv_enable_SM;
  logic [CNT_W-1:0]    step_count;
  logic                stale;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    model_cnt = 0;
  bit    exp_dir = 1'b0;
  bit    prev_step = 1'b0;
  rise_t rise_q[$];
  exp_t  sb_q[$];
  vec_t  vecs[NVEC];

  tr_step_ctrl #(
    .WIDTH_IN(WIDTH_IN), .DX1(10), .DX2(100),
    .DEADZONE(9), .P_FAR(P_FAR), .P_MID(P_MID),
    .P_NEAR(P_NEAR), .PULSE_W(PULSE_W),
    .DIR_SETUP(DIR_SETUP), .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tr_mode_enable(tr_mode_enable),
    .data_valid(data_valid),
    .x(x),
    .x0(x0),
    .drv_step(drv_step),
    .drv_dir(drv_dir),
    .drv_enable_SM(drv_enable_SM),
    .step_count(step_count),
    .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and step-rise recorder, sampled 2ns after each edge.
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (!rst_n) begin
      model_cnt = 0;
    end else if (drv_step && !prev_step) begin
      model_cnt = model_cnt + (exp_dir ? 1 : -1);
      rise_q.push_back('{cyc, drv_dir,
        int'($signed(step_count)), model_cnt});
    end
    prev_step = drv_step;
  end

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input logic [WIDTH_IN-1:0] xv,
                        input logic [WIDTH_IN-1:0] x0v);
    x = xv;
    x0 = x0v;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic take_rise(output rise_t r,
                           input int budget);
    int n;
    n = 0;
    while (rise_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rise_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rise_timeout: no step within %0d cycles",
               budget);
      r = '{0, 1'b0, 0, 0};
    end else begin
      r = rise_q.pop_front();
    end
  endtask

  task automatic pulse_width(output int w);
    w = 0;
    while (drv_step && w < 1000) begin
      w++;
      @(negedge clk);
    end
  endtask

  initial begin
    rise_t r1;
    rise_t r2;
    exp_t  e;
    int    t;
    int    w;
    int    n;

    vecs[0] = '{12'd450,  12'd300, P_FAR,  1'b0};
    vecs[1] = '{12'd350,  12'd300, P_MID,  1'b0};
    vecs[2] = '{12'd303,  12'd300, P_NEAR, 1'b0};
    vecs[3] = '{12'd399,  12'd300, P_MID,  1'b0};
    vecs[4] = '{12'd400,  12'd300, P_FAR,  1'b0};
    vecs[5] = '{12'd310,  12'd300, P_MID,  1'b0};
    vecs[6] = '{12'd309,  12'd300, P_NEAR, 1'b0};
    vecs[7] = '{12'd4095, 12'd0,   P_FAR,  1'b0};
    vecs[8] = '{12'd301,  12'd300, P_NEAR, 1'b0};

    rst_n = 1'b0;
    tr_mode_enable = 1'b0;
    data_valid = 1'b0;
    x = '0;
    x0 = '0;
    tick(3);
    check("rst_step", drv_step, 0);
    check("rst_dir", drv_dir, 0);
    check("rst_enable", drv_enable_SM, 0);
    check("rst_count", step_count, 0);
    check("rst_stale", stale, 0);

    rst_n = 1'b1;
    tr_mode_enable = 1'b1;
    tick(3);
    check("idle_no_sample_en", drv_enable_SM, 0);

    // First sample: FAR, moving down.
    rise_q.delete();
    sample(12'd500, 12'd300);
    t = cyc;
    for (int k = 1; k <= 5; k++) begin
      take_rise(r1, 200);
      if (k == 1)
        check("first_rise_lat", r1.cyc - t, 3);
      else
        check($sformatf("far_period%0d", k),
              r1.cyc - r2.cyc, P_FAR);
      check($sformatf("far_dir%0d", k), r1.dir, 0);
      check($sformatf("far_count%0d", k),
            r1.count, r1.model);
      pulse_width(w);
      check($sformatf("far_width%0d", k), w, PULSE_W);
      r2 = r1;
    end
    check("count_after5", r1.count, -5);

    // Zone table.
    for (int i = 0; i < NVEC; i++) begin
      sample(vecs[i].x, vecs[i].x0);
      sb_q.push_back('{vecs[i].period, vecs[i].dir});
      rise_q.delete();
      take_rise(r1, 400);
      pulse_width(w);
      check($sformatf("vec%0d_width", i), w, PULSE_W);
      take_rise(r2, 400);
      e = sb_q.pop_front();
      check($sformatf("vec%0d_period", i),
            r2.cyc - r1.cyc, e.period);
      check($sformatf("vec%0d_dir", i), r2.dir, e.dir);
      check($sformatf("vec%0d_count", i),
            r2.count, r2.model);
    end

    // Deadzone hysteresis.
    sample(12'd300, 12'd300);
    tick(PULSE_W + 2);
    check("dz_zero_enable", drv_enable_SM, 0);
    rise_q.delete();
    sample(12'd305, 12'd300);
    tick(30);
    check("dz_small_steps", rise_q.size(), 0);
    check("dz_small_enable", drv_enable_SM, 0);
    rise_q.delete();
    sample(12'd309, 12'd300);
    t = cyc;
    tick(1);
    check("dz_track_enable", drv_enable_SM, 1);
    take_rise(r1, 100);
    check("dz_track_lat", r1.cyc - t, 2);

    // Reversal requested mid-pulse.
    exp_dir = 1'b1;
    sample(12'd100, 12'd200);
    tick(3);
    check("rev_pulse_kept", drv_step, 1);
    check("rev_dir_old", drv_dir, 0);
    tick(1);
    check("rev_pulse_end", drv_step, 0);
    tick(1);
    check("rev_dir_new", drv_dir, 1);
    check("rev_enable", drv_enable_SM, 1);
    take_rise(r2, 100);
    check("rev_first_step", r2.cyc - r1.cyc,
          PULSE_W + 1 + DIR_SETUP + 1);
    check("rev_step_dir", r2.dir, 1);
    check("rev_count", r2.count, r2.model);
    take_rise(r1, 100);
    check("rev_period", r1.cyc - r2.cyc, P_FAR);
    check("rev_count2", r1.count, r1.model);

    // Abort mid-pulse, then re-enable.
    tr_mode_enable = 1'b0;
    tick(1);
    check("abort_step", drv_step, 0);
    check("abort_enable", drv_enable_SM, 0);
    tick(3);
    tr_mode_enable = 1'b1;
    rise_q.delete();
    t = cyc;
    take_rise(r1, 100);
    check("reenable_lat", r1.cyc - t, 3);

    // Watchdog.
    sample(12'd100, 12'd200);
    t = cyc;
    n = 0;
    while (!stale && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    check("wd_stale", stale, 1);
    check("wd_time", cyc - t, TIMEOUT);
    check("wd_step", drv_step, 0);
    check("wd_enable", drv_enable_SM, 0);
    rise_q.delete();
    tick(40);
    check("wd_no_steps", rise_q.size(), 0);
    check("wd_stale_held", stale, 1);
    sample(12'd100, 12'd200);
    t = cyc;
    check("wd_stale_clr", stale, 0);
    take_rise(r1, 100);
    check("wd_resume_lat", r1.cyc - t, 3);

    // Asynchronous reset mid-pulse.
    rise_q.delete();
    take_rise(r1, 100);
    #2;
    rst_n = 1'b0;
    exp_dir = 1'b0;
    #1;
    check("arst_step", drv_step, 0);
    check("arst_dir", drv_dir, 0);
    check("arst_enable", drv_enable_SM, 0);
    check("arst_count", step_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    check("arst_idle", drv_enable_SM, 0);
    check("arst_count_held", step_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
